softmax_controller_16: RTL

Pass sequencer for the 16-bit softmax datapath. It accepts a start request and a vector length, then clears the stage blocks. It launches the four stages in order (MAX, EXP_SUM, LN, NORM) and waits for each stage's done edge. It also counts the final output stream and reports completion, timeout or length/count errors. It sits above the compute blocks and supplies their shared `number_of_data` and clear signals, because stage done flags and stream counters do not self-reset between passes.

---
 rtl/softmax_controller_16.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/softmax_controller_16.sv
// softmax_controller_16: pass sequencer for the 16-bit softmax datapath.
// Clears the stage blocks, launches MAX -> EXP_SUM -> LN -> NORM in order,
// waits for each stage's done rising edge, counts the NORM output stream and
// reports success, timeout, bad length or count mismatch.
//
// Handshake: ctrl_start_i is a request that is accepted only in IDLE (not
// queued otherwise); each stage is launched by a one-cycle one-hot pulse on
// ctrl_stage_start_o and acknowledged by a rising edge on its bit of
// ctrl_stage_done_i; a level that is already high on entry is not an edge.
module softmax_controller_16 #(
  parameter int data_size = 16,
  parameter int max_len   = 10,
  parameter int timeout   = 1024
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       ctrl_start_i,
  input  logic [7:0] ctrl_number_of_data_i,
  input  logic       ctrl_abort_i,
  input  logic [3:0] ctrl_stage_done_i,
  input  logic       ctrl_out_valid_i,
  output logic [3:0] ctrl_stage_start_o,
  output logic       ctrl_clear_o,
  output logic [7:0] ctrl_number_of_data_o,
  output logic       ctrl_busy_o,
  output logic       ctrl_done_o,
  output logic       ctrl_error_o,
  output logic [1:0] ctrl_error_code_o,
  output logic [2:0] ctrl_state_o
);

  // Reject parameter values the counters cannot represent.
  if (timeout < 2 || timeout > 65535 || max_len < 1 || max_len > 255 || data_size < 1) begin : g_bad_params
    $error("softmax_controller_16: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_MAX     = 3'd2,
    S_EXP_SUM = 3'd3,
    S_LN      = 3'd4,
    S_NORM    = 3'd5,
    S_DONE    = 3'd6,
    S_FLUSH   = 3'd7
  } state_t;

  localparam logic [1:0]  CodeNone     = 2'd0;
  localparam logic [1:0]  CodeBadLen   = 2'd1;
  localparam logic [1:0]  CodeTimeout  = 2'd2;
  localparam logic [1:0]  CodeMismatch = 2'd3;
  localparam logic [15:0] WdogLast     = 16'(timeout - 1);
  localparam logic [7:0]  MaxLen       = 8'(max_len);

  state_t      state_q, state_d;
  logic [1:0]  fail_code;
  logic [3:0]  done_prev_q;
  logic [3:0]  done_edge;
  logic        cur_edge;
  logic        len_ok;
  logic        wdog_hit;
  logic [15:0] wdog_q, wdog_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [7:0]  len_q, len_d;
  logic [3:0]  start_q, start_d;
  logic        clear_q, clear_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  assign done_edge = ctrl_stage_done_i & ~done_prev_q;
  assign len_ok    = (ctrl_number_of_data_i != 8'd0) && (ctrl_number_of_data_i <= MaxLen);
  assign wdog_hit  = (wdog_q == WdogLast);
  // The valid arriving with the NORM done edge is part of the final count.
  assign cnt_inc   = (ctrl_out_valid_i && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

  // State register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic: abort beats a done edge, which beats the watchdog.
  always_comb begin
    state_d   = state_q;
    fail_code = CodeNone;
    cur_edge  = 1'b0;
    case (state_q)
      S_MAX:     cur_edge = done_edge[0];
      S_EXP_SUM: cur_edge = done_edge[1];
      S_LN:      cur_edge = done_edge[2];
      S_NORM:    cur_edge = done_edge[3];
      default:   cur_edge = 1'b0;
    endcase
    case (state_q)
      S_IDLE: begin
        if (ctrl_start_i && len_ok) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = ctrl_abort_i ? S_FLUSH : S_MAX;
      end
      S_MAX, S_EXP_SUM, S_LN, S_NORM: begin
        if (ctrl_abort_i) begin
          state_d = S_FLUSH;
        end else if (cur_edge) begin
          case (state_q)
            S_MAX:     state_d = S_EXP_SUM;
            S_EXP_SUM: state_d = S_LN;
            S_LN:      state_d = S_NORM;
            default: begin
              if (cnt_inc == len_q) begin
                state_d = S_DONE;
              end else begin
                state_d   = S_FLUSH;
                fail_code = CodeMismatch;
              end
            end
          endcase
        end else if (wdog_hit) begin
          state_d   = S_FLUSH;
          fail_code = CodeTimeout;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values, all taken from the state being entered.
  always_comb begin
    start_d = 4'b0000;
    if (state_d != state_q) begin
      case (state_d)
        S_MAX:     start_d = 4'b0001;
        S_EXP_SUM: start_d = 4'b0010;
        S_LN:      start_d = 4'b0100;
        S_NORM:    start_d = 4'b1000;
        default:   start_d = 4'b0000;
      endcase
    end
    clear_d = (state_d == S_CLEAR) || (state_d == S_FLUSH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);

    err_d  = err_q;
    code_d = code_q;
    len_d  = len_q;
    if (state_q == S_IDLE && ctrl_start_i) begin
      if (len_ok) begin
        len_d  = ctrl_number_of_data_i;
        err_d  = 1'b0;
        code_d = CodeNone;
      end else begin
        err_d  = 1'b1;
        code_d = CodeBadLen;
      end
    end
    if (fail_code != CodeNone) begin
      err_d  = 1'b1;
      code_d = fail_code;
    end

    // Watchdog restarts on every state change.
    wdog_d = (state_d != state_q) ? 16'd0 : wdog_q + 16'd1;
    if (state_d == S_IDLE) wdog_d = 16'd0;

    cnt_d = cnt_q;
    if (state_d == S_NORM && state_q != S_NORM) cnt_d = 8'd0;
    else if (state_q == S_NORM)                  cnt_d = cnt_inc;
  end

  // Registered outputs and pass bookkeeping.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      done_prev_q <= 4'b0000;
      wdog_q      <= 16'd0;
      cnt_q       <= 8'd0;
      len_q       <= 8'd0;
      start_q     <= 4'b0000;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= CodeNone;
    end else begin
      done_prev_q <= ctrl_stage_done_i;
      wdog_q      <= wdog_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      start_q     <= start_d;
      clear_q     <= clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign ctrl_stage_start_o    = start_q;
  assign ctrl_clear_o          = clear_q;
  assign ctrl_number_of_data_o = len_q;
  assign ctrl_busy_o           = busy_q;
  assign ctrl_done_o           = done_q;
  assign ctrl_error_o          = err_q;
  assign ctrl_error_code_o     = code_q;
  assign ctrl_state_o          = state_q;

endmodule
